// File: rtl/mash_seq_decoder.sv
// Receive-side decoder for the MASH divider-ratio stream: averages 2^W valid
// samples and recovers the integer part, the 24-bit fraction and the min/max sample.
module mash_seq_decoder #(
    parameter int DW   = 8,
    parameter int MAXW = 16,
    parameter int FW   = 24
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [4:0]    i_win_log2,
    input  logic [7:0]    i_skip,
    input  logic [DW-1:0] i_mash_in,
    input  logic          i_in_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_int,
    output logic [7:0]    o_msb,
    output logic [7:0]    o_isb,
    output logic [7:0]    o_lsb,
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_max
);

    localparam int AW = DW + MAXW;
    localparam int CW = MAXW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACC, S_DONE} state_t;

    state_t        r_state;
    logic [4:0]    r_win;
    logic [7:0]    r_skip_cnt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_sum;
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_int;
    logic [FW-1:0] r_frac;
    logic [DW-1:0] r_omin;
    logic [DW-1:0] r_omax;
    logic          r_done;

    logic [4:0]    w_win_eff;
    logic [CW-1:0] w_target;
    logic          w_last;
    logic [4:0]    w_frac_shift;

    // Window exponent is clamped to 1..MAXW so the window is never a single sample.
    always_comb begin
        // NOTE: default first so every path assigns w_win_eff and no latch is inferred.
        w_win_eff = i_win_log2;
        if (i_win_log2 == 5'd0) begin
            w_win_eff = 5'd1;
        end else if (i_win_log2 > 5'(MAXW)) begin
            w_win_eff = 5'(MAXW);
        end
    end

    assign w_target     = CW'(1) << r_win;
    assign w_last       = (r_cnt + CW'(1)) == w_target;
    assign w_frac_shift = 5'(FW) - r_win;

    // NOTE: all state, including result registers, uses non-blocking assignments and async reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_win      <= '0;
            r_skip_cnt <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_int      <= '0;
            r_frac     <= '0;
            r_omin     <= '0;
            r_omax     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_win      <= w_win_eff;
                        r_skip_cnt <= i_skip;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_min      <= '1;
                        r_max      <= '0;
                        r_state    <= (i_skip != 8'd0) ? S_SETTLE : S_ACC;
                    end
                end
                S_SETTLE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (i_in_valid) begin
                        if (r_skip_cnt != 8'd0) begin
                            r_skip_cnt <= r_skip_cnt - 8'd1;
                        end
                        if (r_skip_cnt <= 8'd1) begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (i_in_valid) begin
                        r_sum <= r_sum + AW'(i_mash_in);
                        r_cnt <= r_cnt + CW'(1);
                        if (i_mash_in < r_min) r_min <= i_mash_in;
                        if (i_mash_in > r_max) r_max <= i_mash_in;
                        if (w_last) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        // Remainder bits of the sum land left-justified in the fraction word.
                        r_int   <= DW'(r_sum >> r_win);
                        r_frac  <= FW'(r_sum << w_frac_shift);
                        r_omin  <= r_min;
                        r_omax  <= r_max;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_int  = r_int;
    assign o_msb  = r_frac[23:16];
    assign o_isb  = r_frac[15:8];
    assign o_lsb  = r_frac[7:0];
    assign o_min  = r_omin;
    assign o_max  = r_omax;

endmodule

// File: tb/tb_mash_seq_decoder.sv
// Directed self-checking bench for mash_seq_decoder: hand-computed window
// averages, skip handling, invalid gaps, W clamping, abort and async reset.
module tb_mash_seq_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] win;
    logic [7:0] skip;
    logic [7:0] mash;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] r_int;
    logic [7:0] msb;
    logic [7:0] isb;
    logic [7:0] lsb;
    logic [7:0] vmin;
    logic [7:0] vmax;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mash_seq_decoder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_win_log2 (win),
        .i_skip     (skip),
        .i_mash_in  (mash),
        .i_in_valid (valid),
        .o_busy     (busy),
        .o_done     (done),
        .o_int      (r_int),
        .o_msb      (msb),
        .o_isb      (isb),
        .o_lsb      (lsb),
        .o_min      (vmin),
        .o_max      (vmax)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] e_int, input logic [23:0] e_frac,
                             input logic [7:0] e_min, input logic [7:0] e_max);
        check({tag, "_int"},  32'(r_int), 32'(e_int));
        check({tag, "_frac"}, 32'({msb, isb, lsb}), 32'(e_frac));
        check({tag, "_min"},  32'(vmin), 32'(e_min));
        check({tag, "_max"},  32'(vmax), 32'(e_max));
    endtask

    // Pulses start for one edge, then scrambles win/skip to prove they were latched.
    task automatic start_meas(input logic [4:0] w, input logic [7:0] s);
        start = 1'b1;
        win   = w;
        skip  = s;
        @(negedge clk);
        start = 1'b0;
        win   = 5'd2;
        skip  = 8'd7;
    endtask

    task automatic feed(input logic [7:0] v, input logic vl);
        mash  = v;
        valid = vl;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int  n;
        bit  saw;

        rst = 1'b0; start = 1'b0; abort = 1'b0; win = '0; skip = '0; mash = '0; valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_res("rst0", 8'd0, 24'd0, 8'd0, 8'd0);
        check("rst0_busy", 32'(busy), 32'd0);
        check("rst0_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Constant 100, W=4: done 17 edges after the start edge.
        mash = 8'd100; valid = 1'b1;
        start_meas(5'd4, 8'd0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 40, n);
        check("t1_latency", 32'(n), 32'd17);
        check("t1_idle_at_done", 32'(busy), 32'd0);
        check_res("t1", 8'd100, 24'h000000, 8'd100, 8'd100);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_hold_int", 32'(r_int), 32'd100);

        // 4x101 + 12x100 = 1604 over 16; a start mid-window must be ignored.
        start_meas(5'd4, 8'd0);
        for (int j = 0; j < 16; j++) begin
            if (j == 5) begin start = 1'b1; win = 5'd1; end
            else start = 1'b0;
            feed((j < 4) ? 8'd101 : 8'd100, 1'b1);
        end
        start = 1'b0;
        wait_done("t2", 10, n);
        check("t2_latency", 32'(n), 32'd1);
        check_res("t2", 8'd100, 24'h400000, 8'd100, 8'd101);

        // Skip 3 samples of 255, then 4 samples of 50 (W=2).
        start_meas(5'd2, 8'd3);
        check("t3_busy_settle", 32'(busy), 32'd1);
        feed(8'd255, 1'b1);
        feed(8'd255, 1'b1);
        feed(8'd255, 1'b1);
        mash = 8'd50;
        wait_done("t3", 20, n);
        check("t3_latency", 32'(n), 32'd5);
        check_res("t3", 8'd50, 24'h000000, 8'd50, 8'd50);

        // Alternating valid; valid samples 7,8,... sum 60 over 8; invalid 200s ignored.
        start_meas(5'd3, 8'd0);
        saw = 1'b0;
        for (int j = 0; j < 15; j++) begin
            if (j % 2 == 0) feed((j % 4 == 0) ? 8'd7 : 8'd8, 1'b1);
            else            feed(8'd200, 1'b0);
            if (done === 1'b1) saw = 1'b1;
        end
        check("t4_no_early_done", 32'(saw), 32'd0);
        mash = 8'd200; valid = 1'b0;
        wait_done("t4", 10, n);
        check("t4_latency", 32'(n), 32'd1);
        check_res("t4", 8'd7, 24'h800000, 8'd7, 8'd8);

        // W=0 is clamped to a window of 2: (10+11)/2.
        start_meas(5'd0, 8'd0);
        feed(8'd10, 1'b1);
        feed(8'd11, 1'b1);
        valid = 1'b0;
        wait_done("t5a", 10, n);
        check("t5a_latency", 32'(n), 32'd1);
        check_res("t5a", 8'd10, 24'h800000, 8'd10, 8'd11);

        // W=31 clamps to 16: 65536 samples of 255, no accumulator wrap.
        mash = 8'd255; valid = 1'b1;
        start_meas(5'd31, 8'd0);
        wait_done("t5b", 70000, n);
        check("t5b_latency", 32'(n), 32'd65537);
        check_res("t5b", 8'd255, 24'h000000, 8'd255, 8'd255);

        // Abort mid-ACC: no done, previous results kept.
        start_meas(5'd4, 8'd0);
        repeat (5) feed(8'd1, 1'b1);
        abort = 1'b1;
        feed(8'd1, 1'b1);
        abort = 1'b0;
        check("t6_abort_idle", 32'(busy), 32'd0);
        saw = 1'b0;
        for (int j = 0; j < 20; j++) begin
            feed(8'd1, 1'b1);
            if (done === 1'b1) saw = 1'b1;
        end
        check("t6_no_done", 32'(saw), 32'd0);
        check_res("t6", 8'd255, 24'h000000, 8'd255, 8'd255);

        // Abort on the same cycle as the final sample wins over ACC->DONE.
        start_meas(5'd1, 8'd0);
        feed(8'd9, 1'b1);
        abort = 1'b1;
        feed(8'd9, 1'b1);
        abort = 1'b0;
        valid = 1'b0;
        saw = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        check("t7_no_done", 32'(saw), 32'd0);
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_hold_int", 32'(r_int), 32'd255);

        // Async reset mid-ACC clears everything without waiting for a clock edge.
        mash = 8'd77; valid = 1'b1;
        start_meas(5'd4, 8'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_res("t8_rst", 8'd0, 24'd0, 8'd0, 8'd0);
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean restart; start wins over a simultaneous abort in IDLE.
        abort = 1'b1;
        start_meas(5'd1, 8'd0);
        abort = 1'b0;
        check("t9_busy", 32'(busy), 32'd1);
        feed(8'd3, 1'b1);
        feed(8'd4, 1'b1);
        valid = 1'b0;
        wait_done("t9", 10, n);
        check("t9_latency", 32'(n), 32'd1);
        check_res("t9", 8'd3, 24'h800000, 8'd3, 8'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mash_seq_decoder.md
Name: mash_seq_decoder

Overview:
- Receive-side decoder for the MASH divider-ratio stream, i.e. the 8-bit per-cycle output of the NCSP MASH top.
- Averages a window of 2^W valid samples and recovers the integer part and the 24-bit fractional word (msb/isb/lsb layout).
- Also reports the min/max instantaneous ratio seen in the window.
- Used in loopback self-test and bring-up to confirm that the programmed int/frac words are reproduced on average.

Parameters:
- DW, 8, width of the incoming ratio sample and of o_int.
- MAXW, 16, maximum log2 window size. Accumulator width is DW+MAXW = 24.
- FW, 24, recovered fraction width, split into three 8-bit bytes.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous and active-high.
- i_start  input  1  measurement start pulse. Accepted only in IDLE.
- i_abort  input  1  abandon the current measurement.
- i_win_log2  input  5  window size exponent W.
- i_skip  input  8  number of valid samples discarded before accumulation starts.
- i_mash_in  input  8  MASH ratio sample.
- i_in_valid  input  1  qualifies i_mash_in.
- o_busy  output  1  high in SETTLE, ACC and DONE.
- o_done  output  1  one-cycle pulse; results are updated in the same cycle.
- o_int  output  8  recovered integer = floor(sum / 2^W).
- o_msb  output  8  fraction bits [23:16].
- o_isb  output  8  fraction bits [15:8].
- o_lsb  output  8  fraction bits [7:0].
- o_min  output  8  smallest accumulated sample in the window.
- o_max  output  8  largest accumulated sample in the window.

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE.
  - All outputs are 0. The accumulator, counters, latched W and latched skip are all 0.
- W latch at start: Weff = 1 if i_win_log2 = 0; 16 if i_win_log2 > 16; otherwise i_win_log2. Both Weff and i_skip are latched when start is accepted; input changes during the measurement are ignored.
- IDLE:
  - On i_start: clear sum; set min = 0xFF, max = 0x00; load counters.
  - Go to SETTLE if skip ≠ 0, otherwise go to ACC.
- SETTLE:
  - Each cycle with i_in_valid=1 decrements the skip counter; the sample is discarded.
  - When the last skipped sample is consumed, go to ACC on the next edge.
- ACC:
  - Each cycle with i_in_valid=1: sum += i_mash_in (zero-extended to 24 bits); update min and max; increment the sample counter.
  - Cycles with i_in_valid=0 leave all state unchanged.
  - After the 2^Weff-th sample is accepted (edge k), go to DONE.
- DONE (edge k+1):
  - o_int = sum >> Weff. This cannot overflow: max 255·2^W / 2^W = 255.
  - Fraction = (sum mod 2^Weff) << (24 − Weff), driven on {o_msb, o_isb, o_lsb}.
  - o_min and o_max are loaded.
  - o_done = 1 for exactly one cycle, then return to IDLE.
- Latency: results and o_done appear one edge after the edge that accepts the final sample.
- Result holding: result outputs hold their values until the next o_done or reset. A new start does not clear them.
- i_start while not in IDLE: ignored, no queuing.
- i_abort (any state other than IDLE):
  - Go to IDLE on the next edge. No o_done; results are unchanged.
  - i_abort has priority over sample acceptance and over the ACC→DONE transition in the same cycle.
  - i_abort together with i_start in IDLE: start wins.
- Counters: the sample counter is 17 bits (it must reach 2^16). The skip counter is 8 bits and does not wrap.
- o_busy: combinational from state.

Test Plan:
- Constant 100 on every cycle, i_win_log2=4, skip=0: o_done 17 edges after the start edge. Required: o_int=100, frac=0x000000, min=max=100.
- 16 samples, 4×101 and 12×100, W=4: o_int=100, {msb,isb,lsb}=0x40_00_00, min=100, max=101.
- skip=3; first 3 valid samples 255, then constant 50; W=2: o_int=50, frac=0, max=50 (skipped samples excluded).
- i_in_valid toggling 1/0, samples 7,8 repeating, W=3: the result waits for 8 valid samples; o_int=7, frac=0x800000. Invalid samples of 200 do not affect the result.
- i_win_log2=0 → window of 2; i_win_log2=31 with all 255 → 65536 samples, o_int=255, frac=0, no wrap.
- Abort during ACC: no o_done, previous results kept. Assert i_rst mid-ACC: all outputs are 0 immediately and state is IDLE. The next start measures cleanly.
